dm_write_buffer: RTL

//  Data-memory interface stage directly downstream of the core's MEM stage (DM_* ports).

---
 rtl/dm_write_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/dm_write_buffer.sv
// dm_write_buffer: posted-store FIFO with load bypass and req/ack memory drain/fetch
module dm_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_enable,
  input  logic              DM_read,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, READ, RDONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] rdata_q, hit_data;
  logic is_st, is_ld, full, push, pop, hit, miss;
  assign is_st = DM_enable & DM_write;
  assign is_ld = DM_enable & DM_read & ~DM_write;
  assign full = count == CW'(DEPTH);
  assign push = is_st & ~full;
  assign pop = (state == DRAIN) & mem_ack;
  assign miss = is_ld & ~hit;
  assign dm_stall = (is_st & full) | (miss & (state != RDONE));
  assign DM_out = state == RDONE ? rdata_q : hit ? hit_data : '0;
  // Walk oldest to newest so the last match wins.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (is_ld && CW'(i) < count && buf_addr[head + PW'(i)] == DM_address) begin
        hit = 1'b1;
        hit_data = buf_data[head + PW'(i)];
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (miss ? READ : count != '0 ? DRAIN : IDLE)
             : state == RDONE ? IDLE
             : mem_ack        ? (state == READ ? RDONE : IDLE)
             : state;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= DM_address;
      buf_data[tail] <= DM_in;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      count <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      if (state == IDLE && state_nx != IDLE) begin
        mem_req   <= 1'b1;
        mem_we    <= state_nx == DRAIN;
        mem_addr  <= state_nx == DRAIN ? buf_addr[head] : DM_address;
        mem_wdata <= buf_data[head];
      end
      if ((state == DRAIN || state == READ) && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (state == READ && mem_ack) rdata_q <= mem_rdata;
    end
  end
endmodule
